// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the BCD stopwatch: the FSM
//                state encoding, the BCD digit type and the seconds-digit tops.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_ONES_TOP = 4'd9;
    localparam bcd_t SEC_TENS_TOP = 4'd5;
    localparam bcd_t MIN_DIGIT_TOP = 4'd9;

endpackage
`default_nettype wire

// File: rtl/stopwatch_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD counter digit counting 0..TOP. The carry is
//                combinational so a chain of digits ripples in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t TOP = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    assign carry = inc && (digit == TOP);

    // Digit register: clear wins over increment; wraps to zero past TOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= carry ? bcd_t'(0) : bcd_t'(digit + 4'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd
//  Description : MM:SS BCD stopwatch with start/stop/clear control, counting
//                seconds on rising edges of an external tick square wave.
//                Optional lap-hold display snapshot when STOPWATCH_LAP_EN is
//                defined (adds the lap input).
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MIN_TOP = 59
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic start_stop,
    input  logic clear,
`ifdef STOPWATCH_LAP_EN
    input  logic lap,
`endif
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic running,
    output logic wrap
);

    localparam bcd_t C_MIN_TOP_TENS = bcd_t'(MIN_TOP / 10);
    localparam bcd_t C_MIN_TOP_ONES = bcd_t'(MIN_TOP % 10);

    logic   r_tick_q;
    logic   r_ss_q;
    logic   r_wrap;
    state_t r_state;
    state_t w_next;

    logic w_tick_rise;
    logic w_ss_rise;
    logic w_inc;
    bcd_t w_so, w_st, w_mo, w_mt;
    logic w_so_carry, w_st_carry, w_mo_carry, w_mt_carry;
    logic w_min_at_top;
    logic w_min_inc;
    logic w_min_clr;
    logic w_wrap_evt;

    assign w_tick_rise = tick && !r_tick_q;
    assign w_ss_rise   = start_stop && !r_ss_q;

    // Count only in RUN; clear suppresses the increment in the same cycle.
    assign w_inc = (r_state == RUN) && w_tick_rise && !clear;

    // Minutes roll over at MIN_TOP rather than at 99, so the minute pair is
    // cleared on the seconds carry out of MIN_TOP:59 instead of incremented.
    assign w_min_at_top = (w_mt == C_MIN_TOP_TENS) && (w_mo == C_MIN_TOP_ONES);
    assign w_wrap_evt   = w_st_carry && w_min_at_top;
    assign w_min_inc    = w_st_carry && !w_min_at_top;
    // w_mt_carry cannot occur with MIN_TOP <= 99; folded in defensively.
    assign w_min_clr    = clear || w_wrap_evt || w_mt_carry;

    // Edge-detect history flops for tick and start_stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_q <= 1'b0;
            r_ss_q   <= 1'b0;
        end else begin
            r_tick_q <= tick;
            r_ss_q   <= start_stop;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: start_stop rise toggles RUN/PAUSED, clear forces IDLE.
    always_comb begin
        w_next = r_state;
        if (w_ss_rise) begin
            case (r_state)
                IDLE:    w_next = RUN;
                RUN:     w_next = PAUSED;
                PAUSED:  w_next = RUN;
                default: w_next = IDLE;
            endcase
        end
        if (clear) begin
            w_next = IDLE;
        end
    end

    // One-cycle wrap pulse aligned with the 00:00 load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_evt;
        end
    end

    bcd_digit #(.TOP(SEC_ONES_TOP)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_inc),
        .digit(w_so), .carry(w_so_carry)
    );

    bcd_digit #(.TOP(SEC_TENS_TOP)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_so_carry),
        .digit(w_st), .carry(w_st_carry)
    );

    bcd_digit #(.TOP(MIN_DIGIT_TOP)) u_min_ones (
        .clk(clk), .rst(rst), .clr(w_min_clr), .inc(w_min_inc),
        .digit(w_mo), .carry(w_mo_carry)
    );

    bcd_digit #(.TOP(MIN_DIGIT_TOP)) u_min_tens (
        .clk(clk), .rst(rst), .clr(w_min_clr), .inc(w_mo_carry),
        .digit(w_mt), .carry(w_mt_carry)
    );

    assign running = (r_state == RUN);
    assign wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
    logic        r_lap_q;
    logic        r_frozen;
    logic [15:0] r_snap;
    logic        w_lap_rise;

    assign w_lap_rise = lap && !r_lap_q;

    // Lap hold: first lap rise in RUN snapshots the live count; a further
    // lap rise or a clear releases the freeze. Counting continues beneath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap_q  <= 1'b0;
            r_frozen <= 1'b0;
            r_snap   <= '0;
        end else begin
            r_lap_q <= lap;
            if (clear) begin
                r_frozen <= 1'b0;
            end else if (w_lap_rise) begin
                if (r_frozen) begin
                    r_frozen <= 1'b0;
                end else if (r_state == RUN) begin
                    r_frozen <= 1'b1;
                    r_snap   <= {w_mt, w_mo, w_st, w_so};
                end
            end
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} =
        r_frozen ? r_snap : {w_mt, w_mo, w_st, w_so};
`else
    assign {min_tens, min_ones, sec_tens, sec_ones} = {w_mt, w_mo, w_st, w_so};
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_bcd
//  Description : Self-checking bench for stopwatch_bcd. Two instances
//                (MIN_TOP=59 and MIN_TOP=1) share stimulus; a seconds-count
//                reference model predicts every output each cycle.
//                Lap checks are compiled in with STOPWATCH_LAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;

    logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
    logic       run0, run1, wrap0, wrap1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_bcd #(.MIN_TOP(59)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .running(run0), .wrap(wrap0)
    );

    stopwatch_bcd #(.MIN_TOP(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .wrap(wrap1)
    );

    // Reference model: elapsed seconds modulo (MIN_TOP+1)*60 per instance.
    int m_mod [2] = '{3600, 120};
    int m_cnt [2] = '{0, 0};
    int m_snap[2] = '{0, 0};
    bit m_wrap[2] = '{0, 0};
    bit m_frozen = 0;
    bit m_running = 0;
    bit m_paused = 0;
    bit p_tick = 0, p_ss = 0, p_lap = 0;
    int wraps1 = 0;
    int wraps0 = 0;

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit rt, rs, rl;
        rt = tick && !p_tick;
        rs = start_stop && !p_ss;
        rl = lap && !p_lap;
        m_wrap = '{0, 0};
        if (rst) begin
            m_running = 0; m_paused = 0; m_frozen = 0;
            m_cnt = '{0, 0};
            p_tick = 0; p_ss = 0; p_lap = 0;
        end else begin
            if (clear) begin
                m_running = 0; m_paused = 0; m_frozen = 0;
                m_cnt = '{0, 0};
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (rl) begin
                    if (m_frozen) m_frozen = 0;
                    else if (m_running) begin
                        m_frozen = 1;
                        m_snap = m_cnt;
                    end
                end
`endif
                if (m_running && rt) begin
                    for (int i = 0; i < 2; i++) begin
                        m_wrap[i] = (m_cnt[i] == m_mod[i] - 1);
                        m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
                    end
                end
                if (rs) begin
                    if (m_running) begin m_running = 0; m_paused = 1; end
                    else begin m_running = 1; m_paused = 0; end
                end
            end
            p_tick = tick; p_ss = start_stop; p_lap = lap;
        end
    endtask

    task automatic compare();
        check("digits0", {mt0, mo0, st0, so0}, to_bcd(m_frozen ? m_snap[0] : m_cnt[0]));
        check("digits1", {mt1, mo1, st1, so1}, to_bcd(m_frozen ? m_snap[1] : m_cnt[1]));
        check("running0", 16'(run0), 16'(m_running));
        check("running1", 16'(run1), 16'(m_running));
        check("wrap0", 16'(wrap0), 16'(m_wrap[0]));
        check("wrap1", 16'(wrap1), 16'(m_wrap[1]));
        if (wrap0 === 1'b1) wraps0++;
        if (wrap1 === 1'b1) wraps1++;
    endtask

    task automatic step(input logic t, input logic s, input logic c,
                        input logic r = 1'b0, input logic l = 1'b0);
        tick = t; start_stop = s; clear = c; rst = r; lap = l;
        @(posedge clk);
        #1;
        model_update();
        compare();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_digits", {mt0, mo0, st0, so0}, 16'h0000);
        check("reset_running", 16'(run0), 16'h0);

        // Ticks without start are ignored
        ticks(3);
        check("idle_ticks_digits", {mt0, mo0, st0, so0}, 16'h0000);
        check("idle_ticks_running", 16'(run0), 16'h0);

        // Start then 60 ticks -> 01:00 on both; 60 more wraps MIN_TOP=1
        restart();
        wraps0 = 0; wraps1 = 0;
        ticks(60);
        check("sixty_digits0", {mt0, mo0, st0, so0}, 16'h0100);
        check("sixty_digits1", {mt1, mo1, st1, so1}, 16'h0100);
        ticks(60);
        check("wrap_digits1", {mt1, mo1, st1, so1}, 16'h0000);
        check("wrap_count1", 16'(wraps1), 16'd1);
        check("wrap_count0", 16'(wraps0), 16'd0);
        check("wrap_running1", 16'(run1), 16'h1);

        // Pause coinciding with a tick at 00:09
        restart();
        ticks(9);
        step(1'b1, 1'b1, 1'b0);
        check("pause_tick_digits", {mt0, mo0, st0, so0}, 16'h0010);
        check("pause_tick_running", 16'(run0), 16'h0);
        step(1'b0, 1'b0, 1'b0);
        ticks(4);
        check("paused_hold_digits", {mt0, mo0, st0, so0}, 16'h0010);

        // Clear overrides tick and start_stop at 00:42
        restart();
        ticks(42);
        step(1'b1, 1'b1, 1'b1);
        check("clear_digits", {mt0, mo0, st0, so0}, 16'h0000);
        check("clear_running", 16'(run0), 16'h0);
        step(1'b0, 1'b0, 1'b0);

        // Held start_stop makes only one transition
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check("held_ss_running", 16'(run0), 16'h1);
        step(1'b0, 1'b0, 1'b0);

        // Reset mid-count with a concurrent tick rise
        ticks(59);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_mid_digits", {mt0, mo0, st0, so0}, 16'h0000);
        step(1'b0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
        // Lap hold and release
        restart();
        ticks(5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        ticks(10);
        check("lap_hold_digits", {mt0, mo0, st0, so0}, 16'h0005);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_release_digits", {mt0, mo0, st0, so0}, 16'h0015);
        step(1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic against the model
        restart();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 399) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
